umi_isolate_ctrl: RTL and testbench

UMI_ISOLATE_CTRL -- requirements
Module: umi_isolate_ctrl

---
 rtl/umi_iso_pkg.sv | 27 ++
 rtl/umi_iso_timer.sv | 35 +++
 rtl/umi_isolate_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_umi_isolate_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/umi_iso_pkg.sv
// Shared types and default constants for the UMI power-domain isolation controller.
package umi_iso_pkg;

  // Controller states. Binary encoded; OFF is the reset state.
  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_ISO   = 3'd2,
    ST_OFF   = 3'd3,
    ST_WAKE  = 3'd4
  } iso_state_e;

  localparam int DEF_CNTW      = 8;
  localparam int DEF_DRAIN_MAX = 1024;
  localparam int DEF_ISO_DLY   = 2;
  localparam int DEF_SETTLE    = 16;

  // Largest of three values, used to size the shared phase timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/umi_iso_timer.sv
// Loadable, clearable up-counter with a terminal-count flag. One instance is
// time-shared by the DRAIN, ISO and WAKE phases of the isolation controller.
module umi_iso_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] count_r;

  // Counter register: clear wins over load, load wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (en) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == tc_val);

endmodule

// File: rtl/umi_isolate_ctrl.sv
// Power-domain isolation controller for a UMI link: gates new requests,
// drains in-flight traffic, raises isolation, and releases it once the
// domain supply has been stable for SETTLE cycles.
module umi_isolate_ctrl
  import umi_iso_pkg::*;
#(
  parameter int CNTW      = DEF_CNTW,
  parameter int DRAIN_MAX = DEF_DRAIN_MAX,
  parameter int ISO_DLY   = DEF_ISO_DLY,
  parameter int SETTLE    = DEF_SETTLE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iso_req,
  input  logic            pwr_good,
  input  logic            req_valid_in,
  output logic            req_ready_out,
  output logic            req_valid_out,
  input  logic            req_ready_in,
  input  logic            resp_valid,
  input  logic            resp_ready,
  output logic            isolate,
  output logic            iso_ack,
  output logic            drain_timeout,
  output logic [CNTW-1:0] outstanding
);

  localparam int TMR_MAX = max3(DRAIN_MAX, ISO_DLY, SETTLE);
  localparam int TW      = $clog2(TMR_MAX + 1);

  localparam logic [TW-1:0]   DRAIN_TC = TW'(DRAIN_MAX - 1);
  localparam logic [TW-1:0]   ISO_TC   = TW'(ISO_DLY - 1);
  localparam logic [TW-1:0]   WAKE_TC  = TW'(SETTLE - 1);
  // The OFF cycle that launches WAKE already saw pwr_good=1, so WAKE starts
  // counting at one; release happens after SETTLE consecutive good cycles.
  localparam logic [TW-1:0]   WAKE_LD  = TW'(1);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  iso_state_e      state_r;
  iso_state_e      state_nxt_s;
  logic            in_run_s;
  logic            req_fire_s;
  logic            resp_fire_s;
  logic [CNTW-1:0] cnt_nxt_s;
  logic            tmr_clear_s;
  logic            tmr_load_s;
  logic            tmr_en_s;
  logic [TW-1:0]   tmr_tc_val_s;
  logic            tmr_tc_s;
  logic            set_timeout_s;
  logic            clr_timeout_s;

  // The gate is the only combinational output path; it is closed in every
  // state but RUN, and reset forces OFF so it is also closed during reset.
  assign in_run_s      = (state_r == ST_RUN);
  assign req_valid_out = in_run_s & req_valid_in;
  assign req_ready_out = in_run_s & req_ready_in;
  assign req_fire_s    = req_valid_out & req_ready_in;
  assign resp_fire_s   = resp_valid & resp_ready;

  umi_iso_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmr_clear_s),
    .load     (tmr_load_s),
    .load_val (WAKE_LD),
    .en       (tmr_en_s),
    .tc_val   (tmr_tc_val_s),
    .tc       (tmr_tc_s)
  );

  // Next outstanding count: saturating up/down, cleared while OFF.
  always_comb begin
    cnt_nxt_s = outstanding;
    if (state_r == ST_OFF) begin
      cnt_nxt_s = {CNTW{1'b0}};
    end else if (req_fire_s && !resp_fire_s && (outstanding != CNT_MAX)) begin
      cnt_nxt_s = outstanding + CNT_ONE;
    end else if (!req_fire_s && resp_fire_s && (outstanding != {CNTW{1'b0}})) begin
      cnt_nxt_s = outstanding - CNT_ONE;
    end else begin
      cnt_nxt_s = outstanding;
    end
  end

  // Next-state and timer control. DRAIN looks at the next outstanding count
  // so ISO begins the cycle right after the last response returns.
  always_comb begin
    state_nxt_s   = state_r;
    tmr_clear_s   = 1'b0;
    tmr_load_s    = 1'b0;
    tmr_en_s      = 1'b0;
    tmr_tc_val_s  = {TW{1'b0}};
    set_timeout_s = 1'b0;
    clr_timeout_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        tmr_clear_s = 1'b1;
        // Only leave when no valid is pending or it fires now, so an
        // asserted valid is never withdrawn from downstream.
        if (iso_req && (!req_valid_in || req_fire_s)) begin
          state_nxt_s   = ST_DRAIN;
          clr_timeout_s = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        tmr_tc_val_s = DRAIN_TC;
        if (cnt_nxt_s == {CNTW{1'b0}}) begin
          state_nxt_s = ST_ISO;
          tmr_clear_s = 1'b1;
        end else if (tmr_tc_s) begin
          state_nxt_s   = ST_ISO;
          tmr_clear_s   = 1'b1;
          set_timeout_s = 1'b1;
        end else if (!iso_req) begin
          state_nxt_s = ST_RUN;
          tmr_clear_s = 1'b1;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_ISO: begin
        tmr_tc_val_s = ISO_TC;
        if (tmr_tc_s) begin
          state_nxt_s = ST_OFF;
          tmr_clear_s = 1'b1;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_OFF: begin
        if (!iso_req && pwr_good) begin
          state_nxt_s = ST_WAKE;
          tmr_load_s  = 1'b1;
        end else begin
          tmr_clear_s = 1'b1;
        end
      end
      ST_WAKE: begin
        tmr_tc_val_s = WAKE_TC;
        if (iso_req) begin
          state_nxt_s = ST_OFF;
          tmr_clear_s = 1'b1;
        end else if (!pwr_good) begin
          tmr_clear_s = 1'b1;
        end else if (tmr_tc_s) begin
          state_nxt_s = ST_RUN;
          tmr_clear_s = 1'b1;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_OFF;
        tmr_clear_s = 1'b1;
      end
    endcase
  end

  // State register; reset parks the controller isolated in OFF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_OFF;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered isolation outputs, decoded from the state being entered so
  // they change on the same edge as the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isolate <= 1'b1;
      iso_ack <= 1'b1;
    end else begin
      isolate <= (state_nxt_s != ST_RUN) && (state_nxt_s != ST_DRAIN);
      iso_ack <= (state_nxt_s == ST_OFF) || (state_nxt_s == ST_WAKE);
    end
  end

  // Sticky drain-timeout flag, cleared only when a new drain begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_timeout <= 1'b0;
    end else if (clr_timeout_s) begin
      drain_timeout <= 1'b0;
    end else if (set_timeout_s) begin
      drain_timeout <= 1'b1;
    end else begin
      drain_timeout <= drain_timeout;
    end
  end

  // In-flight request counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= {CNTW{1'b0}};
    end else begin
      outstanding <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_umi_isolate_ctrl.sv
// Directed, self-checking bench for umi_isolate_ctrl with default parameters.
module tb_umi_isolate_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       iso_req;
  logic       pwr_good;
  logic       req_valid_in;
  logic       req_ready_out;
  logic       req_valid_out;
  logic       req_ready_in;
  logic       resp_valid;
  logic       resp_ready;
  logic       isolate;
  logic       iso_ack;
  logic       drain_timeout;
  logic [7:0] outstanding;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rv;
    logic       rr;
    logic       sv;
    logic       sr;
    logic       exp_rvo;
    logic       exp_rro;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs [10];

  umi_isolate_ctrl #(
    .CNTW(8), .DRAIN_MAX(1024), .ISO_DLY(2), .SETTLE(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .iso_req       (iso_req),
    .pwr_good      (pwr_good),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_valid_out (req_valid_out),
    .req_ready_in  (req_ready_in),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .isolate       (isolate),
    .iso_ack       (iso_ack),
    .drain_timeout (drain_timeout),
    .outstanding   (outstanding)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    // rv rr sv sr | rvo rro outstanding(before edge)
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

    // Reset state, with the upstream side trying to push a request.
    reset = 1'b1; iso_req = 1'b0; pwr_good = 1'b1;
    req_valid_in = 1'b1; req_ready_in = 1'b1; resp_valid = 1'b0; resp_ready = 1'b0;
    tick(); tick();
    chk("rst_isolate", isolate, 1);
    chk("rst_iso_ack", iso_ack, 1);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_timeout", drain_timeout, 0);
    chk("rst_valid_out", req_valid_out, 0);
    chk("rst_ready_out", req_ready_out, 0);
    req_valid_in = 1'b0; req_ready_in = 1'b0;

    // Release: isolation drops on the 16th edge.
    reset = 1'b0;
    repeat (15) tick();
    chk("wake_hold15", isolate, 1);
    tick();
    chk("wake_release16", isolate, 0);
    chk("wake_ack_low", iso_ack, 0);

    // Transparent gate and outstanding counting in RUN.
    for (int i = 0; i < 10; i++) begin
      req_valid_in = vecs[i].rv; req_ready_in = vecs[i].rr;
      resp_valid = vecs[i].sv;   resp_ready = vecs[i].sr;
      #1;
      chk($sformatf("vec%0d_valid_out", i), req_valid_out, vecs[i].exp_rvo);
      chk($sformatf("vec%0d_ready_out", i), req_ready_out, vecs[i].exp_rro);
      chk($sformatf("vec%0d_outstanding", i), outstanding, vecs[i].exp_out);
      tick();
    end
    req_valid_in = 1'b0; req_ready_in = 1'b0; resp_valid = 1'b0; resp_ready = 1'b0;

    // Three requests, drain completed by three spaced responses.
    req_valid_in = 1'b1; req_ready_in = 1'b1;
    repeat (3) tick();
    req_valid_in = 1'b0; req_ready_in = 1'b0;
    chk("drain_pre_count", outstanding, 3);
    iso_req = 1'b1;
    tick();
    req_valid_in = 1'b1; req_ready_in = 1'b1;
    #1;
    chk("drain_gate_valid", req_valid_out, 0);
    chk("drain_gate_ready", req_ready_out, 0);
    req_valid_in = 1'b0; req_ready_in = 1'b0;
    for (int r = 0; r < 3; r++) begin
      repeat (4) tick();
      resp_valid = 1'b1; resp_ready = 1'b1;
      tick();
      resp_valid = 1'b0; resp_ready = 1'b0;
      if (r < 2) begin
        chk($sformatf("drain_hold_r%0d", r), isolate, 0);
        chk($sformatf("drain_count_r%0d", r), outstanding, 2 - r);
      end
    end
    chk("iso_entry_isolate", isolate, 1);
    chk("iso_entry_ack", iso_ack, 0);
    tick();
    chk("iso_ack_wait", iso_ack, 0);
    tick();
    chk("iso_ack_rise", iso_ack, 1);
    chk("drain_no_timeout", drain_timeout, 0);

    // Wake back up, then drain with one request that never completes.
    iso_req = 1'b0;
    repeat (16) tick();
    chk("rewake_release", isolate, 0);
    req_valid_in = 1'b1; req_ready_in = 1'b1;
    tick();
    req_valid_in = 1'b0; req_ready_in = 1'b0;
    iso_req = 1'b1;
    tick();
    repeat (1023) tick();
    chk("timeout_not_yet", drain_timeout, 0);
    chk("timeout_isolate_low", isolate, 0);
    tick();
    chk("timeout_set", drain_timeout, 1);
    chk("timeout_isolate", isolate, 1);
    chk("timeout_count_kept", outstanding, 1);
    tick(); tick();
    chk("timeout_off_ack", iso_ack, 1);
    tick();
    chk("off_clears_count", outstanding, 0);

    // WAKE interrupted by a pwr_good drop at settle count 10.
    iso_req = 1'b0;
    repeat (10) tick();
    pwr_good = 1'b0;
    repeat (3) tick();
    chk("wake_drop_hold", isolate, 1);
    pwr_good = 1'b1;
    repeat (15) tick();
    chk("wake_restart_hold", isolate, 1);
    tick();
    chk("wake_restart_release", isolate, 0);
    chk("timeout_sticky", drain_timeout, 1);

    // Reset in the middle of DRAIN with four requests outstanding.
    req_valid_in = 1'b1; req_ready_in = 1'b1;
    repeat (4) tick();
    req_valid_in = 1'b0; req_ready_in = 1'b0;
    iso_req = 1'b1;
    tick();
    chk("timeout_cleared", drain_timeout, 0);
    chk("drain4_count", outstanding, 4);
    tick();
    chk("drain4_isolate", isolate, 0);
    reset = 1'b1;
    #1;
    chk("async_isolate", isolate, 1);
    chk("async_outstanding", outstanding, 0);
    req_valid_in = 1'b1; req_ready_in = 1'b1;
    tick();
    chk("rst_edge_isolate", isolate, 1);
    chk("rst_edge_ack", iso_ack, 1);
    chk("rst_edge_count", outstanding, 0);
    chk("rst_edge_gate", req_valid_out, 0);
    req_valid_in = 1'b0; req_ready_in = 1'b0;
    iso_req = 1'b0;
    reset = 1'b0;
    repeat (15) tick();
    chk("post_rst_hold", isolate, 1);
    tick();
    chk("post_rst_release", isolate, 0);

    // Saturation of the outstanding counter.
    req_valid_in = 1'b1; req_ready_in = 1'b1;
    repeat (254) tick();
    chk("sat_254", outstanding, 254);
    repeat (2) tick();
    chk("sat_256", outstanding, 255);
    tick();
    chk("sat_hold", outstanding, 255);
    req_valid_in = 1'b0; req_ready_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
